// File: rtl/demux5x32_buf.sv
// demux5x32_buf: buffered 1-to-5 word demultiplexer with single-entry holding registers per channel.
// Illegal selects are accepted and dropped, setting a sticky error flag and a saturating drop counter.
module demux5x32_buf #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Y4,
    output logic             V0,
    output logic             V1,
    output logic             V2,
    output logic             V3,
    output logic             V4,
    input  logic             R0,
    input  logic             R1,
    input  logic             R2,
    input  logic             R3,
    input  logic             R4,
    output logic             Err,
    output logic [CNTW-1:0]  DropCnt
);
    logic [4:0]       v_q, v_d, rdy, fill;
    logic [WIDTH-1:0] y_q [5];
    logic [WIDTH-1:0] y_d [5];
    logic             err_q, err_d, legal, accept;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [2:0]       ch;

    assign rdy = {R4, R3, R2, R1, R0};

    // Selects 011 and 100 share channel 3 to match the datapath mux encoding.
    always_comb begin
        legal    = S <= 3'd5;
        ch       = (S == 3'd5) ? 3'd4 : (S == 3'd4) ? 3'd3 : legal ? S : 3'd0;
        In_Ready = legal ? (~v_q[ch] | rdy[ch]) : 1'b1;
        accept   = In_Valid & In_Ready;
        err_d    = err_q | (accept & ~legal);
        cnt_d    = (accept && !legal && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        for (int k = 0; k < 5; k++) begin
            fill[k] = accept & legal & (ch == 3'(k));
            v_d[k]  = fill[k] | (v_q[k] & ~rdy[k]);
            y_d[k]  = fill[k] ? D : y_q[k];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            v_q   <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
            for (int k = 0; k < 5; k++) y_q[k] <= '0;
        end else begin
            v_q   <= v_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < 5; k++) y_q[k] <= y_d[k];
        end
    end

    assign {V4, V3, V2, V1, V0} = v_q;
    assign Y0      = y_q[0];
    assign Y1      = y_q[1];
    assign Y2      = y_q[2];
    assign Y3      = y_q[3];
    assign Y4      = y_q[4];
    assign Err     = err_q;
    assign DropCnt = cnt_q;
endmodule
